// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - one-command-at-a-time player movement sequencer for the 10x10 dungeon grid
// Checks move targets against grid edges and walls, reveals the surrounding fog-of-war cells, then requests a redraw.
module move_sequencer #(
   parameter int GRID_W    = 10,
   parameter int GRID_H    = 10,
   parameter int POS_W     = 16,
   parameter int START_POS = 50,
   parameter int EXIT_POS  = 59,
   parameter int WALL_CODE = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd,
   output logic             map_rd_en,
   output logic [POS_W-1:0] map_rd_addr,
   input  logic [2:0]       map_rd_data,
   output logic             reveal_we,
   output logic [POS_W-1:0] reveal_addr,
   output logic             disp_req,
   input  logic             disp_ack,
   output logic [POS_W-1:0] cur_pos,
   output logic             at_exit,
   output logic             bump,
   output logic             quit
);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT, S_REVEAL, S_DISP, S_DONE} state_t;

   localparam logic signed [5:0] GW        = 6'(GRID_W);
   localparam logic signed [5:0] GH        = 6'(GRID_H);
   localparam logic signed [5:0] START_ROW = 6'(START_POS / GRID_W);
   localparam logic signed [5:0] START_COL = 6'(START_POS % GRID_W);
   localparam logic [POS_W-1:0]  START_IDX = POS_W'(START_POS);
   localparam logic [POS_W-1:0]  EXIT_IDX  = POS_W'(EXIT_POS);
   localparam logic [POS_W-1:0]  GW_IDX    = POS_W'(GRID_W);
   localparam logic [2:0]        WALL      = 3'(WALL_CODE);

   function automatic logic in_grid(input logic signed [5:0] r, input logic signed [5:0] c);
      return !r[5] && (r < GH) && !c[5] && (c < GW);
   endfunction

   function automatic logic [POS_W-1:0] cell_idx(input logic signed [5:0] r, input logic signed [5:0] c);
      return POS_W'($unsigned(r)) * GW_IDX + POS_W'($unsigned(c));
   endfunction

   state_t                state_q, state_d;
   logic [3:0]            slot_q, slot_d;
   logic [2:0]            cmd_q, cmd_d;
   logic signed [5:0]     row_q, row_d, col_q, col_d;
   logic [POS_W-1:0]      cur_pos_q, cur_pos_d;
   logic                  at_exit_q, at_exit_d;
   logic                  quit_q, quit_d;

   logic signed [5:0]     t_row, t_col, rv_dr, rv_dc, rv_row, rv_col;
   logic                  is_move;
   logic                  ready_c, rd_en_c, we_c, disp_c, bump_c;

   always_comb begin
      t_row   = row_q;
      t_col   = col_q;
      is_move = 1'b1;
      case (cmd_q)
         3'd1:    t_col = col_q + 6'sd1;
         3'd2:    t_col = col_q - 6'sd1;
         3'd3:    t_row = row_q - 6'sd1;
         3'd4:    t_row = row_q + 6'sd1;
         default: is_move = 1'b0;
      endcase
   end

   // Fixed diamond-shaped reveal order, radius 2 on the axes and 1 on the diagonals
   always_comb begin
      rv_dr = 6'sd0;
      rv_dc = 6'sd0;
      case (slot_q)
         4'd0:    begin rv_dr = -6'sd2; rv_dc =  6'sd0; end
         4'd1:    begin rv_dr = -6'sd1; rv_dc = -6'sd1; end
         4'd2:    begin rv_dr = -6'sd1; rv_dc =  6'sd0; end
         4'd3:    begin rv_dr = -6'sd1; rv_dc =  6'sd1; end
         4'd4:    begin rv_dr =  6'sd0; rv_dc = -6'sd2; end
         4'd5:    begin rv_dr =  6'sd0; rv_dc = -6'sd1; end
         4'd6:    begin rv_dr =  6'sd0; rv_dc =  6'sd0; end
         4'd7:    begin rv_dr =  6'sd0; rv_dc =  6'sd1; end
         4'd8:    begin rv_dr =  6'sd0; rv_dc =  6'sd2; end
         4'd9:    begin rv_dr =  6'sd1; rv_dc = -6'sd1; end
         4'd10:   begin rv_dr =  6'sd1; rv_dc =  6'sd0; end
         4'd11:   begin rv_dr =  6'sd1; rv_dc =  6'sd1; end
         default: begin rv_dr =  6'sd2; rv_dc =  6'sd0; end
      endcase
      rv_row = row_q + rv_dr;
      rv_col = col_q + rv_dc;
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      cmd_d       = cmd_q;
      row_d       = row_q;
      col_d       = col_q;
      cur_pos_d   = cur_pos_q;
      at_exit_d   = at_exit_q;
      quit_d      = quit_q;
      ready_c     = 1'b0;
      rd_en_c     = 1'b0;
      we_c        = 1'b0;
      disp_c      = 1'b0;
      bump_c      = 1'b0;
      map_rd_addr = cell_idx(t_row, t_col);
      reveal_addr = cell_idx(rv_row, rv_col);
      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            if (cmd_valid) begin
               cmd_d   = cmd;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (is_move) begin
               if (in_grid(t_row, t_col)) begin
                  rd_en_c = 1'b1;
                  state_d = S_WAIT;
               end else begin
                  bump_c  = 1'b1;
                  state_d = S_DISP;
               end
            end else if (cmd_q == 3'd5) begin
               quit_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (map_rd_data == WALL) begin
               bump_c  = 1'b1;
               state_d = S_DISP;
            end else begin
               row_d     = t_row;
               col_d     = t_col;
               cur_pos_d = cell_idx(t_row, t_col);
               at_exit_d = (cell_idx(t_row, t_col) == EXIT_IDX);
               slot_d    = 4'd0;
               state_d   = S_REVEAL;
            end
         end
         S_REVEAL: begin
            we_c = in_grid(rv_row, rv_col);
            if (slot_q == 4'd12) begin
               slot_d  = 4'd0;
               state_d = S_DISP;
            end else begin
               slot_d = slot_q + 4'd1;
            end
         end
         S_DISP: begin
            disp_c = 1'b1;
            if (disp_ack) state_d = quit_q ? S_DONE : S_IDLE;
         end
         S_DONE:  ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_REVEAL;
         slot_q    <= 4'd0;
         cmd_q     <= 3'd0;
         row_q     <= START_ROW;
         col_q     <= START_COL;
         cur_pos_q <= START_IDX;
         at_exit_q <= 1'b0;
         quit_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         cmd_q     <= cmd_d;
         row_q     <= row_d;
         col_q     <= col_d;
         cur_pos_q <= cur_pos_d;
         at_exit_q <= at_exit_d;
         quit_q    <= quit_d;
      end
   end

   // Strobes are held low while reset is asserted even though the reset state is mid-reveal
   assign cmd_ready = ready_c & ~rst;
   assign map_rd_en = rd_en_c & ~rst;
   assign reveal_we = we_c & ~rst;
   assign disp_req  = disp_c & ~rst;
   assign bump      = bump_c & ~rst;
   assign cur_pos   = cur_pos_q;
   assign at_exit   = at_exit_q;
   assign quit      = quit_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - scoreboard bench for move_sequencer
// Expected strobe events are queued by a grid-level model; a negedge monitor pops and compares them.
module tb_move_sequencer;
   localparam int POS_W = 16;
   localparam int K_RD = 0, K_WR = 1, K_BUMP = 2, K_DISP = 3;

   typedef struct {
      int kind;
      int val;
      int ex;
   } ev_t;

   logic             clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0;
   logic [2:0]       cmd = 3'd0;
   logic             cmd_ready, map_rd_en, reveal_we, disp_req, at_exit, bump, quit;
   logic [POS_W-1:0] map_rd_addr, reveal_addr, cur_pos;
   logic [2:0]       map_rd_data = 3'd0;
   logic             disp_ack = 1'b1;

   int  checks = 0, errors = 0;
   int  map_mem [100];
   int  ack_mode = 1;
   int  m_r, m_c;
   ev_t exp_q [$];
   int  dr [13] = '{-2, -1, -1, -1,  0,  0, 0, 0, 0,  1, 1, 1, 2};
   int  dc [13] = '{ 0, -1,  0,  1, -2, -1, 0, 1, 2, -1, 0, 1, 0};

   move_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
      .map_rd_en(map_rd_en), .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
      .reveal_we(reveal_we), .reveal_addr(reveal_addr), .disp_req(disp_req), .disp_ack(disp_ack),
      .cur_pos(cur_pos), .at_exit(at_exit), .bump(bump), .quit(quit)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (map_rd_en) map_rd_data <= (map_rd_addr < 100) ? 3'(map_mem[map_rd_addr]) : 3'd0;

   initial forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
         0:       disp_ack = 1'b0;
         1:       disp_ack = 1'b1;
         default: disp_ack = 1'($urandom % 2);
      endcase
   end

   function automatic bit ing(input int r, input int c);
      return r >= 0 && r < 10 && c >= 0 && c < 10;
   endfunction

   task automatic push_ev(input int kind, input int val, input int ex);
      ev_t e;
      e.kind = kind; e.val = val; e.ex = ex;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic push_disp();
      push_ev(K_DISP, m_r * 10 + m_c, (m_r * 10 + m_c == 59) ? 1 : 0);
   endtask

   task automatic push_reveal();
      for (int i = 0; i < 13; i++)
         if (ing(m_r + dr[i], m_c + dc[i])) push_ev(K_WR, (m_r + dr[i]) * 10 + m_c + dc[i], 0);
      push_disp();
   endtask

   task automatic target(input int c, output int tr, output int tc);
      tr = m_r; tc = m_c;
      case (c)
         1: tc = m_c + 1;
         2: tc = m_c - 1;
         3: tr = m_r - 1;
         default: tr = m_r + 1;
      endcase
   endtask

   task automatic model_cmd(input int c, output bit moved);
      int tr, tc;
      moved = 1'b0;
      if (c >= 1 && c <= 4) begin
         target(c, tr, tc);
         if (!ing(tr, tc)) begin
            push_ev(K_BUMP, m_r * 10 + m_c, 0);
            push_disp();
         end else begin
            push_ev(K_RD, tr * 10 + tc, 0);
            if (map_mem[tr * 10 + tc] == 5) begin
               push_ev(K_BUMP, m_r * 10 + m_c, 0);
               push_disp();
            end else begin
               m_r = tr; m_c = tc; moved = 1'b1;
               push_reveal();
            end
         end
      end
   endtask

   task automatic see(input int kind, input int val, input int ex);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d val=%0d, required no event", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.ex != ex) begin
            errors++;
            $display("FAIL event: got kind=%0d val=%0d ex=%0d, required kind=%0d val=%0d ex=%0d",
                     kind, val, ex, e.kind, e.val, e.ex);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (map_rd_en && reveal_we) begin
            checks++; errors++;
            $display("FAIL strobe_overlap: got rd_en=1 we=1, required not both");
         end
         if (map_rd_en) see(K_RD, int'(map_rd_addr), 0);
         if (reveal_we) see(K_WR, int'(reveal_addr), 0);
         if (bump) see(K_BUMP, int'(cur_pos), 0);
         if (disp_req && disp_ack) see(K_DISP, int'(cur_pos), int'(at_exit));
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      #1;
      chk("rst_cur_pos", int'(cur_pos), 50);
      chk("rst_reveal_we", int'(reveal_we), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 0);
      chk("rst_quit", int'(quit), 0);
      chk("rst_at_exit", int'(at_exit), 0);
      chk("rst_strobes", int'({map_rd_en, disp_req, bump}), 0);
      exp_q.delete();
      m_r = 5; m_c = 0;
      push_reveal();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(cmd_ready || quit) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL idle_timeout: got cmd_ready=%0d after %0d cycles, required 1", cmd_ready, n);
      end
   endtask

   task automatic issue(input int c, output bit acc);
      int n;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk);
      #1;
      cmd = 3'(c);
      cmd_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
      cmd_valid = 1'b0;
      cmd = 3'($urandom);
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", n);
      end
   endtask

   task automatic run_cmd(input int c);
      bit moved, acc;
      int old_pos;
      old_pos = m_r * 10 + m_c;
      model_cmd(c, moved);
      issue(c, acc);
      if (acc && moved) begin
         @(negedge clk);
         @(negedge clk);
         chk("pos_in_wait", int'(cur_pos), old_pos);
         @(negedge clk);
         chk("pos_after_wait", int'(cur_pos), m_r * 10 + m_c);
      end
      wait_idle();
   endtask

   initial begin
      bit moved, acc;
      int tr, tc, c, n;
      for (int i = 0; i < 100; i++) map_mem[i] = $urandom_range(0, 4);
      #2;
      do_reset();
      wait_idle();
      chk("post_reset_pos", int'(cur_pos), 50);
      chk("post_reset_ready", int'(cmd_ready), 1);

      run_cmd(2);
      chk("left_edge_pos", int'(cur_pos), 50);
      map_mem[51] = 4;
      run_cmd(1);
      chk("right_pos", int'(cur_pos), 51);
      map_mem[41] = 5;
      run_cmd(3);
      chk("wall_pos", int'(cur_pos), 51);

      for (int i = 52; i < 59; i++) map_mem[i] = $urandom_range(0, 4);
      map_mem[59] = 3;
      for (int i = 0; i < 8; i++) run_cmd(1);
      chk("exit_pos", int'(cur_pos), 59);
      chk("exit_flag", int'(at_exit), 1);

      for (int i = 0; i < 100; i++) map_mem[i] = ($urandom % 4 == 0) ? 5 : $urandom_range(0, 4);
      ack_mode = 2;
      for (int i = 0; i < 40; i++) begin
         c = $urandom % 8;
         if (c == 5) c = 0;
         run_cmd(c);
      end

      ack_mode = 0;
      model_cmd(4, moved);
      issue(4, acc);
      n = 0;
      while (!disp_req && n < 60) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("hold_disp_req", int'(disp_req), 1);
         chk("hold_cmd_ready", int'(cmd_ready), 0);
         @(negedge clk);
      end
      ack_mode = 1;
      wait_idle();

      c = 1;
      for (int d = 4; d >= 1; d--) begin
         target(d, tr, tc);
         if (ing(tr, tc) && tr * 10 + tc != 50) c = d;
      end
      target(c, tr, tc);
      map_mem[tr * 10 + tc] = 0;
      model_cmd(c, moved);
      issue(c, acc);
      repeat (6) @(posedge clk);
      #1;
      do_reset();
      wait_idle();
      chk("mid_reset_pos", int'(cur_pos), 50);
      chk("mid_reset_queue", exp_q.size(), 0);

      issue(5, acc);
      @(posedge clk);
      #1;
      cmd = 3'd1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("quit_sticky", int'(quit), 1);
         chk("done_ready", int'(cmd_ready), 0);
      end
      cmd_valid = 1'b0;
      chk("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Sequences player movement on the 10x10 dungeon grid, one command at a time. It accepts a move command, checks the target against the grid edges and the shared map RAM (walls), then commits the new position. It then walks the fog-of-war reveal pattern around the player, writing to the bitmap RAM one cell per cycle, and finally requests a map redraw. It sits between the command source and the map/bitmap/display resources and is their only master.

Parameters:
GRID_W, 10, grid columns
GRID_H, 10, grid rows
POS_W, 16, width of linear cell index (row*GRID_W+col)
START_POS, 50, entrance cell and reset position
EXIT_POS, 59, exit cell
WALL_CODE, 5, map tile code that blocks movement

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd  in  3  1=right 2=left 3=up 4=down 5=quit, others=no-op
map_rd_en  out  1  map RAM read strobe
map_rd_addr  out  POS_W  map read cell index
map_rd_data  in  3  tile code, valid exactly 1 cycle after map_rd_en
reveal_we  out  1  bitmap write strobe (data implicitly 1)
reveal_addr  out  POS_W  bitmap cell index
disp_req  out  1  redraw request
disp_ack  in  1  redraw accepted
cur_pos  out  POS_W  current cell index
at_exit  out  1  cur_pos==EXIT_POS
bump  out  1  one-cycle pulse: move rejected
quit  out  1  sticky, quit command accepted

Behaviour:
- Reset (async, any state): state=REVEAL with slot 0, cur_pos=START_POS, row/col tracked internally (5,0), at_exit=0, quit=0, bump=0, cmd_ready=0, map_rd_en=0, reveal_we=0, disp_req=0. A reveal pass and redraw therefore follow every reset.
- States: IDLE, CHECK, WAIT, REVEAL, DISP, DONE. Each state is one cycle, except REVEAL and DISP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd and go to CHECK. No other state asserts cmd_ready.
- CHECK: compute target row/col.
  - Target off grid (col<0, col>=GRID_W, row<0, row>=GRID_H): pulse bump, go to DISP. No map read is issued.
  - In-grid move: map_rd_en=1, map_rd_addr=target, go to WAIT.
  - cmd=5: quit<=1, go to DONE.
  - Other codes: go to IDLE silently. No bump, no redraw.
- WAIT: sample map_rd_data.
  - Value==WALL_CODE: pulse bump, go to DISP.
  - Otherwise: cur_pos/row/col <= target, at_exit <= (target==EXIT_POS), go to REVEAL slot 0.
  - cur_pos changes at the end of WAIT, 3 cycles after the accept edge.
- REVEAL: exactly 13 cycles, slot 0..12, using fixed (drow,dcol) order: (-2,0)(-1,-1)(-1,0)(-1,1)(0,-2)(0,-1)(0,0)(0,1)(0,2)(1,-1)(1,0)(1,1)(2,0).
  - reveal_we=1 and reveal_addr=cell only if that cell is in-grid. Otherwise reveal_we=0 for that slot.
  - After slot 12, go to DISP.
  - Bounds use row/col compares, never wrap via modulo. Row 0 and col 0 are valid.
- DISP: disp_req=1 held until disp_ack sampled high. On that edge go to IDLE (DONE if quit). disp_req is deasserted the cycle after.
- DONE: terminal until reset. cmd_ready=0, all strobes 0, quit=1.
- map_rd_en and reveal_we are never asserted in the same cycle.
- Commands presented while not in IDLE are held by the source (ready/valid). None are dropped or duplicated.

Test Plan:
- Reset, disp_ack tied 1 -> reveal_we pulses on 9 of 13 slots, addrs 30,40,41,50,51,52,60,61,70 in order. Then disp_req for 1 cycle, then cmd_ready=1, cur_pos=50.
- From 50, cmd=2 (left) -> bump pulse in CHECK, map_rd_en never high, cur_pos stays 50, disp_req follows, no reveal writes.
- From 50, cmd=1, map_rd_data=4 -> map_rd_addr=51; cur_pos=51 three cycles after accept; 13-cycle reveal incl. addrs 31 and 53; redraw.
- From 51, cmd=3, map_rd_data=5 (wall at 41) -> bump, cur_pos stays 51, no reveal.
- Walk to 58 then cmd=1 with map_rd_data=3 -> cur_pos=59, at_exit=1. Reveal slots (0,1),(0,2),(-1,1),(1,1) have reveal_we=0 (col>=10).
- Hold disp_ack=0 for 5 cycles -> disp_req stays high and cmd_ready stays 0. Then cmd=5 -> quit=1 and cmd_ready=0 permanently. Assert rst mid-REVEAL -> same-cycle cur_pos=50, reveal_we=0, restarts at slot 0.
